// File: rtl/multdiv_sequencer_if.sv
// Handshake and data bundle between the CPU control unit, the iterative
// multiply/divide unit and the multdiv_sequencer. The master side is the
// surrounding CPU/datapath (it drives the requests and the unit's outputs);
// the slave side is the sequencer itself.
interface multdiv_sequencer_if #(
  parameter int W = 32
);
  logic         op_start;
  logic         op_sel;
  logic [W-1:0] RegA;
  logic [W-1:0] RegB;
  logic         mthi;
  logic         mtlo;
  logic [W-1:0] wdata;
  logic [W-1:0] md_hi;
  logic [W-1:0] md_lo;
  logic         md_reset;
  logic         md_cntrl;
  logic [W-1:0] md_a;
  logic [W-1:0] md_b;
  logic         busy;
  logic         done;
  logic         div_zero_exc;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;

  modport master (
    output op_start, op_sel, RegA, RegB, mthi, mtlo, wdata, md_hi, md_lo,
    input  md_reset, md_cntrl, md_a, md_b, busy, done, div_zero_exc, Hi, Lo
  );

  modport slave (
    input  op_start, op_sel, RegA, RegB, mthi, mtlo, wdata, md_hi, md_lo,
    output md_reset, md_cntrl, md_a, md_b, busy, done, div_zero_exc, Hi, Lo
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// Sequencer for the iterative multiply/divide unit. Latches operands on a
// request, holds the unit in reset except while it iterates, then copies the
// unit's Hi/Lo into the architectural HI/LO registers. A divide by zero is
// trapped up front and never launches the unit. Also services mthi/mtlo.
module multdiv_sequencer #(
  parameter int W           = 32,
  parameter int MULT_CYCLES = 33,
  parameter int DIV_CYCLES  = 33
) (
  input logic                Clk,
  input logic                Reset,
  multdiv_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CAPTURE,
    FAULT
  } state_t;

  // The counter is loaded with N-1 so RUN lasts exactly N cycles.
  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

  state_t       state_q, state_d;
  logic [5:0]   count_q, count_d;
  logic [W-1:0] md_a_q, md_a_d;
  logic [W-1:0] md_b_q, md_b_d;
  logic         md_cntrl_q, md_cntrl_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] lo_q, lo_d;
  logic         done_q, done_d;
  logic         exc_q, exc_d;
  logic         busy;

  assign busy = (state_q == LOAD) || (state_q == RUN);

  // State and datapath registers; an active-low reset aborts any operation.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      md_a_q     <= '0;
      md_b_q     <= '0;
      md_cntrl_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      exc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      md_a_q     <= md_a_d;
      md_b_q     <= md_b_d;
      md_cntrl_q <= md_cntrl_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      exc_q      <= exc_d;
    end
  end

  // Next-state logic; direct HI/LO writes are applied first so a result
  // captured in the same cycle overrides them.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    md_a_d     = md_a_q;
    md_b_d     = md_b_q;
    md_cntrl_d = md_cntrl_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    exc_d      = 1'b0;

    if (!busy) begin
      if (bus.mthi) hi_d = bus.wdata;
      if (bus.mtlo) lo_d = bus.wdata;
    end

    case (state_q)
      IDLE: begin
        if (bus.op_start) begin
          if (bus.op_sel && (bus.RegB == '0)) begin
            state_d = FAULT;
          end else begin
            md_a_d     = bus.RegA;
            md_b_d     = bus.RegB;
            md_cntrl_d = bus.op_sel;
            count_d    = bus.op_sel ? DIV_LOAD : MULT_LOAD;
            state_d    = LOAD;
          end
        end
      end
      LOAD: begin
        state_d = RUN;
      end
      RUN: begin
        if (count_q == '0) begin
          state_d = CAPTURE;
        end else begin
          count_d = count_q - 6'd1;
        end
      end
      CAPTURE: begin
        hi_d    = bus.md_hi;
        lo_d    = bus.md_lo;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      FAULT: begin
        exc_d   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.md_reset     = (state_q != RUN);
  assign bus.md_cntrl     = md_cntrl_q;
  assign bus.md_a         = md_a_q;
  assign bus.md_b         = md_b_q;
  assign bus.busy         = busy;
  assign bus.done         = done_q;
  assign bus.div_zero_exc = exc_q;
  assign bus.Hi           = hi_q;
  assign bus.Lo           = lo_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Testbench for multdiv_sequencer: directed operations against a small
// behavioural multiply/divide unit that only presents its result after
// exactly 33 released cycles, so a wrong RUN length shows up as a bad result.
module tb_multdiv_sequencer;

  logic Clk;
  logic Reset;
  int   testsRun;
  int   testsFailed;

  multdiv_sequencer_if #(.W(32)) bus ();

  multdiv_sequencer #(
    .W(32),
    .MULT_CYCLES(33),
    .DIV_CYCLES(33)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Unit model: latches operands while held in reset, counts released cycles.
  int          unitCount;
  logic [31:0] unitA, unitB;
  logic        unitDiv;
  logic [63:0] unitResult;

  always @(posedge Clk) begin
    if (bus.md_reset) begin
      unitCount <= 0;
      unitA     <= bus.md_a;
      unitB     <= bus.md_b;
      unitDiv   <= bus.md_cntrl;
    end else begin
      unitCount <= unitCount + 1;
    end
  end

  always_comb begin
    unitResult = 64'hBAD0BAD0_BAD0BAD0;
    if (unitCount >= 33) begin
      if (unitDiv) begin
        if (unitB != 32'd0) unitResult = {unitA % unitB, unitA / unitB};
      end else begin
        unitResult = 64'($signed(unitA) * $signed(unitB));
      end
    end
  end

  assign bus.md_hi = unitResult[63:32];
  assign bus.md_lo = unitResult[31:0];

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one operation and watches it until done (bounded); optionally
  // injects op_start plus mthi mid-operation to confirm they are ignored.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic sel, input int injectAt,
                               output int doneCycle, output int busyCnt,
                               output int lowCnt, output bit stable,
                               output bit cntrlHeld);
    doneCycle = -1;
    busyCnt   = 0;
    lowCnt    = 0;
    stable    = 1'b1;
    cntrlHeld = 1'b1;
    bus.op_start = 1'b1;
    bus.op_sel   = sel;
    bus.RegA     = a;
    bus.RegB     = b;
    tick();
    bus.op_start = 1'b0;
    bus.RegA     = 32'hA5A5A5A5;
    bus.RegB     = 32'h5A5A5A5A;
    for (int i = 0; i < 200; i++) begin
      if (bus.busy) busyCnt++;
      if (!bus.md_reset) begin
        lowCnt++;
        if (bus.md_cntrl !== sel) cntrlHeld = 1'b0;
      end
      if (bus.busy && ((bus.md_a !== a) || (bus.md_b !== b))) stable = 1'b0;
      if (bus.done) begin
        doneCycle = i;
        break;
      end
      if (i == injectAt) begin
        bus.op_start = 1'b1;
        bus.op_sel   = 1'b0;
        bus.RegA     = 32'd9;
        bus.RegB     = 32'd9;
        bus.mthi     = 1'b1;
        bus.wdata    = 32'h0000DEAD;
      end
      tick();
      if (i == injectAt) begin
        bus.op_start = 1'b0;
        bus.mthi     = 1'b0;
      end
    end
  endtask

  int doneCycle, busyCnt, lowCnt, excCnt, excCycle;
  bit stable, cntrlHeld, busySeen, lowSeen;

  initial begin
    testsRun     = 0;
    testsFailed  = 0;
    Reset        = 1'b0;
    bus.op_start = 1'b0;
    bus.op_sel   = 1'b0;
    bus.RegA     = '0;
    bus.RegB     = '0;
    bus.mthi     = 1'b0;
    bus.mtlo     = 1'b0;
    bus.wdata    = '0;
    tick();
    tick();

    checkOutput("rst Hi", bus.Hi, 32'd0);
    checkOutput("rst Lo", bus.Lo, 32'd0);
    checkOutput("rst md_a", bus.md_a, 32'd0);
    checkOutput("rst md_reset", 32'(bus.md_reset), 32'd1);
    checkOutput("rst busy", 32'(bus.busy), 32'd0);
    checkOutput("rst done", 32'(bus.done), 32'd0);
    Reset = 1'b1;
    tick();

    // 6 x 7
    applyStimulus(32'd6, 32'd7, 1'b0, -1, doneCycle, busyCnt, lowCnt, stable, cntrlHeld);
    checkOutput("mul done cycle", 32'(doneCycle), 32'd35);
    checkOutput("mul busy cycles", 32'(busyCnt), 32'd34);
    checkOutput("mul md_reset low", 32'(lowCnt), 32'd33);
    checkOutput("mul Hi", bus.Hi, 32'd0);
    checkOutput("mul Lo", bus.Lo, 32'd42);
    tick();
    checkOutput("done one cycle", 32'(bus.done), 32'd0);

    // -3 x 5
    applyStimulus(32'hFFFFFFFD, 32'd5, 1'b0, -1, doneCycle, busyCnt, lowCnt, stable, cntrlHeld);
    checkOutput("neg Hi", bus.Hi, 32'hFFFFFFFF);
    checkOutput("neg Lo", bus.Lo, 32'hFFFFFFF1);
    checkOutput("neg operands stable", 32'(stable), 32'd1);

    // 100 / 7
    applyStimulus(32'd100, 32'd7, 1'b1, -1, doneCycle, busyCnt, lowCnt, stable, cntrlHeld);
    checkOutput("div done cycle", 32'(doneCycle), 32'd35);
    checkOutput("div Lo", bus.Lo, 32'd14);
    checkOutput("div Hi", bus.Hi, 32'd2);
    checkOutput("div cntrl held", 32'(cntrlHeld), 32'd1);
    tick();

    // mthi and mtlo together
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h00000055;
    tick();
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    checkOutput("mthi+mtlo Hi", bus.Hi, 32'h55);
    checkOutput("mthi+mtlo Lo", bus.Lo, 32'h55);

    // Divide by zero with preloaded HI/LO
    bus.mthi  = 1'b1;
    bus.wdata = 32'h11;
    tick();
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h22;
    tick();
    bus.mtlo  = 1'b0;
    checkOutput("preload Hi", bus.Hi, 32'h11);
    checkOutput("preload Lo", bus.Lo, 32'h22);
    bus.op_start = 1'b1;
    bus.op_sel   = 1'b1;
    bus.RegA     = 32'd55;
    bus.RegB     = 32'd0;
    excCnt   = 0;
    excCycle = -1;
    busySeen = 1'b0;
    lowSeen  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.op_start = 1'b0;
      if (bus.busy) busySeen = 1'b1;
      if (!bus.md_reset) lowSeen = 1'b1;
      if (bus.div_zero_exc) begin
        excCnt++;
        if (excCycle < 0) excCycle = i;
      end
    end
    checkOutput("dz exc count", 32'(excCnt), 32'd1);
    checkOutput("dz exc cycle", 32'(excCycle), 32'd1);
    checkOutput("dz busy never", 32'(busySeen), 32'd0);
    checkOutput("dz md_reset never low", 32'(lowSeen), 32'd0);
    checkOutput("dz Hi kept", bus.Hi, 32'h11);
    checkOutput("dz Lo kept", bus.Lo, 32'h22);

    // 4 x 5 with op_start + mthi injected mid-run, then back-to-back 2 x 8
    applyStimulus(32'd4, 32'd5, 1'b0, 10, doneCycle, busyCnt, lowCnt, stable, cntrlHeld);
    checkOutput("inj done cycle", 32'(doneCycle), 32'd35);
    checkOutput("inj Hi", bus.Hi, 32'd0);
    checkOutput("inj Lo", bus.Lo, 32'd20);
    checkOutput("inj operands stable", 32'(stable), 32'd1);
    applyStimulus(32'd2, 32'd8, 1'b0, -1, doneCycle, busyCnt, lowCnt, stable, cntrlHeld);
    checkOutput("b2b done cycle", 32'(doneCycle), 32'd35);
    checkOutput("b2b Lo", bus.Lo, 32'd16);

    // Reset in the middle of RUN
    bus.mthi  = 1'b1;
    bus.wdata = 32'h77;
    tick();
    bus.mthi = 1'b0;
    checkOutput("pre-abort Hi", bus.Hi, 32'h77);
    bus.op_start = 1'b1;
    bus.op_sel   = 1'b0;
    bus.RegA     = 32'd6;
    bus.RegB     = 32'd6;
    tick();
    bus.op_start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    checkOutput("pre-abort busy", 32'(bus.busy), 32'd1);
    Reset = 1'b0;
    #1;
    checkOutput("abort Hi", bus.Hi, 32'd0);
    checkOutput("abort Lo", bus.Lo, 32'd0);
    checkOutput("abort md_reset", 32'(bus.md_reset), 32'd1);
    checkOutput("abort busy", 32'(bus.busy), 32'd0);
    tick();
    tick();
    Reset = 1'b1;
    tick();
    applyStimulus(32'd3, 32'd3, 1'b0, -1, doneCycle, busyCnt, lowCnt, stable, cntrlHeld);
    checkOutput("post-reset done cycle", 32'(doneCycle), 32'd35);
    checkOutput("post-reset Lo", bus.Lo, 32'd9);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
